// File: rtl/frac_logic_pkg.sv
// Shared types and configuration-layout helpers for the fracturable K-input LUT.
// FRAC_LOGIC_K_CFG_PARITY_EN appends an even-parity bit to the configuration chain.
package frac_logic_pkg;

  typedef enum logic [1:0] {
    UNCONFIG   = 2'd0,
    LOADING    = 2'd1,
    CONFIGURED = 2'd2
  } state_t;

  function automatic int cfg_w(input int k);
`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
    return (1 << k) + 3;
`else
    return (1 << k) + 2;
`endif
  endfunction

  function automatic int in_sel_ofs(input int k);
    return 1 << k;
  endfunction

  function automatic int out0_sel_ofs(input int k);
    return (1 << k) + 1;
  endfunction

  function automatic int parity_ofs(input int k);
    return (1 << k) + 2;
  endfunction

endpackage

// File: rtl/frac_logic_k_ccff.sv
// Configuration chain: shift register, load counter and load-tracking state machine.
// FRAC_LOGIC_K_CFG_PARITY_EN adds a registered parity-error flag.
module frac_logic_k_ccff
  import frac_logic_pkg::*;
#(
  parameter int CFG_W = 18
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             ccff_en,
  input  logic             ccff_head,
  output logic [CFG_W-1:0] cfg,
  output logic             cfg_done
`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
  ,
  output logic             cfg_err
`endif
);

  localparam int CNT_W = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state <= UNCONFIG;
      cnt   <= '0;
      cfg   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (ccff_en) cfg <= {cfg[CFG_W-2:0], ccff_head};
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (ccff_en) begin
      case (state)
        UNCONFIG, CONFIGURED: begin
          state_nx = LOADING;
          cnt_nx   = CNT_ONE;
        end
        LOADING: begin
          cnt_nx = cnt + CNT_ONE;
          if (cnt_nx == CNT_FULL) state_nx = CONFIGURED;
        end
        default: begin
          state_nx = UNCONFIG;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_done = (state == CONFIGURED);
  end

`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
  // Parity is taken over the image being completed on this edge, not the current one.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      cfg_err <= 1'b0;
    end else if (state_nx != CONFIGURED) begin
      cfg_err <= 1'b0;
    end else if (state != CONFIGURED) begin
      cfg_err <= ^{cfg[CFG_W-2:0], ccff_head};
    end
  end
`endif

endmodule

// File: rtl/frac_logic_k.sv
// Fracturable K-input LUT with carry, configured through a serial scan chain.
// FRAC_LOGIC_K_CFG_PARITY_EN enables chain parity checking and the cfg_err port.
module frac_logic_k
  import frac_logic_pkg::*;
#(
  parameter int K = 4
) (
  input  logic         prog_clk,
  input  logic         pReset,
  input  logic         ccff_en,
  input  logic         ccff_head,
  input  logic [K-1:0] frac_logic_in,
  input  logic         frac_logic_cin,
  output logic [1:0]   frac_logic_out,
  output logic         frac_logic_cout,
  output logic         ccff_tail,
  output logic         cfg_done
`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
  ,
  output logic         cfg_err
`endif
);

  localparam int LUT_N        = 1 << K;
  localparam int HALF         = LUT_N / 2;
  localparam int CFG_W        = cfg_w(K);
  localparam int IN_SEL_OFS   = in_sel_ofs(K);
  localparam int OUT0_SEL_OFS = out0_sel_ofs(K);

  logic [CFG_W-1:0] cfg;
  logic [HALF-1:0]  tt_lo, tt_hi;
  logic             in_sel, out0_sel;
  logic [K-1:0]     a;
  logic             lo, hi, lutk, enable;

  frac_logic_k_ccff #(
    .CFG_W(CFG_W)
  ) u_ccff (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .ccff_en  (ccff_en),
    .ccff_head(ccff_head),
    .cfg      (cfg),
    .cfg_done (cfg_done)
`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
    ,
    .cfg_err  (cfg_err)
`endif
  );

  always_comb begin
    tt_lo    = cfg[HALF-1:0];
    tt_hi    = cfg[LUT_N-1:HALF];
    in_sel   = cfg[IN_SEL_OFS];
    out0_sel = cfg[OUT0_SEL_OFS];
  end

  // in_sel steers the carry into the second-highest address bit.
  always_comb begin
    a = frac_logic_in;
    if (in_sel) a[K-2] = frac_logic_cin;
  end

  always_comb begin
    lo   = tt_lo[a[K-2:0]];
    hi   = tt_hi[a[K-2:0]];
    lutk = a[K-1] ? hi : lo;
  end

  always_comb begin
`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
    enable = cfg_done & ~cfg_err;
`else
    enable = cfg_done;
`endif
    frac_logic_out  = '0;
    frac_logic_cout = 1'b0;
    if (enable) begin
      frac_logic_out  = {hi, (out0_sel ? lutk : lo)};
      frac_logic_cout = hi ? frac_logic_cin : lo;
    end
    ccff_tail = cfg[CFG_W-1];
  end

endmodule

// File: tb/tb_frac_logic_k.sv
// Directed bench for frac_logic_k (K=4) with a shift-history model checked every cycle.
module tb_frac_logic_k;

  localparam int K  = 4;
  localparam int TT = 1 << K;
`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
  localparam int CFG_W = TT + 3;
`else
  localparam int CFG_W = TT + 2;
`endif

  logic         prog_clk = 1'b0;
  logic         pReset;
  logic         ccff_en;
  logic         ccff_head;
  logic [K-1:0] frac_logic_in;
  logic         frac_logic_cin;
  logic [1:0]   frac_logic_out;
  logic         frac_logic_cout;
  logic         ccff_tail;
  logic         cfg_done;
`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
  logic         cfg_err;
`endif

  int checks = 0;
  int errors = 0;

  frac_logic_k #(.K(K)) dut (
    .prog_clk       (prog_clk),
    .pReset         (pReset),
    .ccff_en        (ccff_en),
    .ccff_head      (ccff_head),
    .frac_logic_in  (frac_logic_in),
    .frac_logic_cin (frac_logic_cin),
    .frac_logic_out (frac_logic_out),
    .frac_logic_cout(frac_logic_cout),
    .ccff_tail      (ccff_tail),
    .cfg_done       (cfg_done)
`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
    ,
    .cfg_err        (cfg_err)
`endif
  );

  always #5 prog_clk = ~prog_clk;

  // Model: the image is the last CFG_W bits shifted in; the LUT is configured
  // whenever the number of shifts since reset is a nonzero multiple of CFG_W.
  logic [CFG_W-1:0] m_img;
  int               m_shifts;

  always @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      m_img    = '0;
      m_shifts = 0;
    end else if (ccff_en) begin
      m_img    = {m_img[CFG_W-2:0], ccff_head};
      m_shifts = m_shifts + 1;
    end
  end

  function automatic logic m_done();
    return (m_shifts > 0) && (m_shifts % CFG_W == 0);
  endfunction

  function automatic logic m_err();
`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
    return m_done() && (^m_img);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] m_outs();
    int  addr, lo_i;
    logic lo, hi, lutk, o0;
    addr = int'(frac_logic_in);
    if (m_img[TT]) addr = (addr & ~(1 << (K - 2))) | (int'(frac_logic_cin) << (K - 2));
    lo_i = addr % (TT / 2);
    lo   = m_img[lo_i];
    hi   = m_img[lo_i + TT / 2];
    lutk = (addr >= TT / 2) ? hi : lo;
    o0   = m_img[TT + 1] ? lutk : lo;
    if (!m_done() || m_err()) return 3'b000;
    return {(hi ? frac_logic_cin : lo), hi, o0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge prog_clk) begin
    logic [2:0] e;
    e = m_outs();
    chk("cyc_out", {30'd0, frac_logic_out}, {30'd0, e[1:0]});
    chk("cyc_cout", {31'd0, frac_logic_cout}, {31'd0, e[2]});
    chk("cyc_tail", {31'd0, ccff_tail}, {31'd0, m_img[CFG_W-1]});
    chk("cyc_done", {31'd0, cfg_done}, {31'd0, m_done()});
`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
    chk("cyc_err", {31'd0, cfg_err}, {31'd0, m_err()});
`endif
  end

  function automatic logic [CFG_W-1:0] mk(input logic o0, input logic isel, input logic [TT-1:0] tbl);
    logic [TT+1:0] body;
    body = {o0, isel, tbl};
`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
    return {^body, body};
`else
    return body;
`endif
  endfunction

  task automatic shift_range(input logic [CFG_W-1:0] img, input int hi_i, input int lo_i);
    for (int i = hi_i; i >= lo_i; i--) begin
      ccff_en   = 1'b1;
      ccff_head = img[i];
      @(posedge prog_clk);
      #1;
      ccff_en   = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge prog_clk);
      #1;
    end
  endtask

  task automatic drive(input logic [K-1:0] v, input logic c);
    frac_logic_in  = v;
    frac_logic_cin = c;
    #1;
  endtask

  logic [CFG_W-1:0] img;

  initial begin
    pReset         = 1'b0;
    ccff_en        = 1'b0;
    ccff_head      = 1'b0;
    frac_logic_in  = '0;
    frac_logic_cin = 1'b0;

    // Reset with random inputs, including random shift requests
    repeat (3) begin
      ccff_en        = 1'($urandom);
      ccff_head      = 1'($urandom);
      frac_logic_in  = K'($urandom);
      frac_logic_cin = 1'($urandom);
      @(posedge prog_clk);
      #1;
      chk("rst_out", {30'd0, frac_logic_out}, 32'd0);
      chk("rst_cout", {31'd0, frac_logic_cout}, 32'd0);
      chk("rst_tail", {31'd0, ccff_tail}, 32'd0);
      chk("rst_done", {31'd0, cfg_done}, 32'd0);
    end
    ccff_en = 1'b0;
    pReset  = 1'b1;
    idle(5);
    chk("idle_done", {31'd0, cfg_done}, 32'd0);

    // Basic load: AND4 on out[0]
    img = mk(1'b1, 1'b0, 16'h8000);
    shift_range(img, CFG_W - 1, 1);
    chk("load_done_early", {31'd0, cfg_done}, 32'd0);
    shift_range(img, 0, 0);
    chk("load_done", {31'd0, cfg_done}, 32'd1);
    chk("load_tail", {31'd0, ccff_tail}, {31'd0, img[CFG_W-1]});
    drive(4'b1111, 1'b0);
    chk("and4_1111", {31'd0, frac_logic_out[0]}, 32'd1);
    drive(4'b1110, 1'b0);
    chk("and4_1110", {31'd0, frac_logic_out[0]}, 32'd0);

    // Reconfigure with a stall in the middle of the stream
    shift_range(img, CFG_W - 1, CFG_W - 9);
    idle(3);
    chk("stall_done", {31'd0, cfg_done}, 32'd0);
    chk("stall_out", {30'd0, frac_logic_out}, 32'd0);
    shift_range(img, CFG_W - 10, 1);
    chk("stall_done_early", {31'd0, cfg_done}, 32'd0);
    shift_range(img, 0, 0);
    chk("stall_done_late", {31'd0, cfg_done}, 32'd1);
    drive(4'b1111, 1'b0);
    chk("stall_1111", {31'd0, frac_logic_out[0]}, 32'd1);
    drive(4'b1110, 1'b0);
    chk("stall_1110", {31'd0, frac_logic_out[0]}, 32'd0);

    // Carry: propagate table
    shift_range(mk(1'b0, 1'b0, 16'hFF00), CFG_W - 1, 0);
    drive(4'b0101, 1'b1);
    chk("cout_prop_c1", {31'd0, frac_logic_cout}, 32'd1);
    drive(4'b0101, 1'b0);
    chk("cout_prop_c0", {31'd0, frac_logic_cout}, 32'd0);

    // Carry: generate table
    shift_range(mk(1'b0, 1'b0, 16'h00FF), CFG_W - 1, 0);
    drive(4'b0010, 1'b0);
    chk("cout_gen_c0", {31'd0, frac_logic_cout}, 32'd1);
    drive(4'b0010, 1'b1);
    chk("cout_gen_c1", {31'd0, frac_logic_cout}, 32'd1);

    // in_sel: carry replaces address bit 2; full sweep checked by the model
    shift_range(mk(1'b1, 1'b1, 16'h6A5C), CFG_W - 1, 0);
    drive(4'b1011, 1'b0);
    chk("insel_c0", {30'd0, frac_logic_out}, 32'd3);
    drive(4'b1011, 1'b1);
    chk("insel_c1", {30'd0, frac_logic_out}, 32'd0);
    for (int v = 0; v < 32; v++) begin
      frac_logic_in  = K'(v);
      frac_logic_cin = v[4];
      idle(1);
    end

    // Reset mid-load discards the partial image
    img = mk(1'b1, 1'b0, 16'h8000);
    shift_range(img, CFG_W - 1, CFG_W - 10);
    #2;
    pReset = 1'b0;
    #1;
    chk("midrst_done", {31'd0, cfg_done}, 32'd0);
    chk("midrst_tail", {31'd0, ccff_tail}, 32'd0);
    idle(2);
    pReset = 1'b1;
    shift_range(img, CFG_W - 1, 1);
    chk("midrst_done_early", {31'd0, cfg_done}, 32'd0);
    shift_range(img, 0, 0);
    chk("midrst_done_full", {31'd0, cfg_done}, 32'd1);
    drive(4'b1111, 1'b0);
    chk("midrst_out", {30'd0, frac_logic_out}, 32'd3);

`ifdef FRAC_LOGIC_K_CFG_PARITY_EN
    // One flipped bit trips the parity check and gates the outputs
    shift_range(img ^ {{(CFG_W-1){1'b0}}, 1'b1}, CFG_W - 1, 0);
    drive(4'b1111, 1'b0);
    chk("par_bad_err", {31'd0, cfg_err}, 32'd1);
    chk("par_bad_out", {30'd0, frac_logic_out}, 32'd0);
    shift_range(img, CFG_W - 1, 0);
    drive(4'b1111, 1'b0);
    chk("par_good_err", {31'd0, cfg_err}, 32'd0);
    chk("par_good_out", {30'd0, frac_logic_out}, 32'd3);
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frac_logic_k.md
FRAC_LOGIC_K -- requirements
Module: frac_logic_k

Interface
REQ-001 SHALL have parameter K, default 4, legal 3..6; the number of LUT inputs.
REQ-002 SHALL have derived constant CFG_W = 2^K+2, or 2^K+3 with FRAC_LOGIC_K_CFG_PARITY_EN; the configuration chain length.
REQ-003 SHALL have port prog_clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port pReset, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port ccff_en, input, 1 bit; shift-enable for the configuration chain.
REQ-006 SHALL have port ccff_head, input, 1 bit; serial configuration data in.
REQ-007 SHALL have port frac_logic_in, input, K bits; LUT address, bit 0 is the LSB.
REQ-008 SHALL have port frac_logic_cin, input, 1 bit; carry in.
REQ-009 SHALL have port frac_logic_out, output, 2 bits; fractured LUT outputs.
REQ-010 SHALL have port frac_logic_cout, output, 1 bit; carry out.
REQ-011 SHALL have port ccff_tail, output, 1 bit; serial configuration data out, equal to cfg[CFG_W-1].
REQ-012 SHALL have port cfg_done, output, 1 bit; high in state CONFIGURED.
REQ-013 SHALL have port cfg_err, output, 1 bit; present only with FRAC_LOGIC_K_CFG_PARITY_EN.

Function
REQ-014 SHALL, on each prog_clk edge with ccff_en=1, shift: cfg[0]<=ccff_head, cfg[i]<=cfg[i-1]; with ccff_en=0, cfg SHALL hold.
REQ-015 SHALL map cfg[2^K-1:0] to the truth table, cfg[2^K] to in_sel, and cfg[2^K+1] to out0_sel; the first bit shifted in lands in the MSB.
REQ-016 SHALL use an effective address a equal to frac_logic_in, except that a[K-2]=frac_logic_cin when in_sel=1.
REQ-017 SHALL compute lo=cfg[a[K-2:0]], hi=cfg[2^(K-1)+a[K-2:0]], and lutk = a[K-1] ? hi : lo.
REQ-018 SHALL drive frac_logic_out[0] = out0_sel ? lutk : lo, and frac_logic_out[1] = hi.
REQ-019 SHALL drive frac_logic_cout = hi ? frac_logic_cin : lo (propagate=hi, generate=lo).
REQ-020 SHALL implement a state machine with states UNCONFIG, LOADING and CONFIGURED, plus a bit counter cnt of width clog2(CFG_W+1).
REQ-021 UNCONFIG SHALL go to LOADING with cnt=1 on a shift.
REQ-022 LOADING SHALL increment cnt per shift and go to CONFIGURED when the shift brings cnt to CFG_W.
REQ-023 LOADING SHALL hold cnt and state while ccff_en=0, with no timeout.
REQ-024 CONFIGURED SHALL go to LOADING with cnt=1 on any shift, which restarts reconfiguration.
REQ-025 cfg_done SHALL rise on the edge that completes shift CFG_W, with zero added latency.
REQ-026 frac_logic_out and frac_logic_cout SHALL be forced to 0 whenever the state is not CONFIGURED; the data path SHALL otherwise be combinational.
REQ-027 ccff_tail SHALL never be gated, so that the chain passes through in every state.

Reset
REQ-028 pReset=0 SHALL asynchronously clear cfg, cnt and cfg_err, and force state UNCONFIG, independent of prog_clk.
REQ-029 During reset, all outputs SHALL be 0: frac_logic_out=2'b00, frac_logic_cout=0, ccff_tail=0, cfg_done=0.
REQ-030 Reset asserted mid-load SHALL discard the partial load; a full CFG_W-bit reload SHALL be required.
REQ-031 Release of pReset SHALL be synchronous-safe; the first shift SHALL be accepted on the first prog_clk edge after deassertion.

Configuration
REQ-032 With macro FRAC_LOGIC_K_CFG_PARITY_EN defined, cfg[2^K+2] SHALL be an even-parity bit over all CFG_W bits.
REQ-033 With the macro defined, cfg_err SHALL be registered high on entry to CONFIGURED when the XOR of cfg is 1, and cleared on leaving CONFIGURED.
REQ-034 With the macro defined, cfg_err=1 SHALL gate frac_logic_out and frac_logic_cout to 0.
REQ-035 Without the macro, CFG_W SHALL be 2^K+2, the cfg_err port SHALL be absent, and no parity logic SHALL exist.

Structure
REQ-036 Package frac_logic_pkg SHALL hold the state enum (UNCONFIG/LOADING/CONFIGURED), the CFG_W function of K, and the field-offset constants (in_sel, out0_sel, parity).
REQ-037 Sub-module frac_logic_k_ccff SHALL contain the shift register, counter and state machine, and export cfg, cfg_done and cfg_err; the LUT/mux/carry datapath SHALL stay in the top module.

Verification
REQ-038 Reset: pReset=0 with random inputs -> all outputs 0; after release with ccff_en=0 for 5 cycles -> cfg_done stays 0.
REQ-039 Load, K=4, CFG_W=18: out0_sel=1, in_sel=0, table 16'h8000, 18 shifts -> cfg_done=1 after the 18th edge; in=4'b1111 -> out[0]=1; in=4'b1110 -> out[0]=0.
REQ-040 Stall: drop ccff_en after 9 shifts for 3 cycles, then resume -> cfg_done only after 18 total shifts, with a loaded image identical to REQ-039.
REQ-041 Carry, K=4: in_sel=0, table 16'hFF00 (hi=1, lo=0), cin=1 -> cout=1; cin=0 -> cout=0; table 16'h00FF -> cout=1 regardless of cin.
REQ-042 Reset mid-load: pReset low after 10 shifts -> cfg_done=0 and ccff_tail=0 immediately; 18 fresh shifts are then required.
REQ-043 Parity, macro on, CFG_W=19: load an image with one flipped bit -> cfg_err=1 and out=2'b00; a correct image -> cfg_err=0.
